divider: RTL and testbench

Multi-cycle 32-bit integer divider for the MIPS execute stage, serving DIV and DIVU. It sits beside the ALU and consumes the ALU's start_div / signed_div request. It returns div_ready and the 64-bit div_result, which the ALU writes to HI/LO. The divider stalls the pipeline implicitly: the ALU keeps stall_div asserted until ready_o is seen.

---
 rtl/divider_if.sv | 12 +
 rtl/divider.sv | 76 +++++++
 tb/tb_divider.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// divider_if: request/response bundle between the ALU and the divider
interface divider_if;
  logic start_i;
  logic signed_i;
  logic annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic ready_o;
  modport master (output start_i, signed_i, annul_i, opdata1_i, opdata2_i, input result_o, ready_o);
  modport slave (input start_i, signed_i, annul_i, opdata1_i, opdata2_i, output result_o, ready_o);
endinterface

// File: rtl/divider.sv
// divider: multi-cycle 32-bit DIV/DIVU restoring divider; define DIVIDER_RADIX4_EN for 2 quotient bits per cycle
module divider (
  input logic clk,
  input logic rst,
  divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
`ifdef DIVIDER_RADIX4_EN
  localparam logic [4:0] LAST = 5'd15;
`else
  localparam logic [4:0] LAST = 5'd31;
`endif
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [63:0] w, w_nx;
  logic [31:0] dvs, mag_a, mag_b, quo, rem;
  logic qneg, rneg, quit;
  function automatic logic [63:0] step(input logic [63:0] x, input logic [31:0] d);
    logic [32:0] t;
    t = x[63:31] - {1'b0, d};
    return t[32] ? {x[62:0], 1'b0} : {t[31:0], x[30:0], 1'b1};
  endfunction
  assign mag_a = (bus.signed_i && bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
  assign mag_b = (bus.signed_i && bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;
`ifdef DIVIDER_RADIX4_EN
  assign w_nx = step(step(w, dvs), dvs);
`else
  assign w_nx = step(w, dvs);
`endif
  assign quo = qneg ? -w_nx[31:0] : w_nx[31:0];
  assign rem = rneg ? -w_nx[63:32] : w_nx[63:32];
  assign quit = bus.annul_i || !bus.start_i;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next-state: abort on annul or dropped start, finish after the last iteration
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start_i && !bus.annul_i) state_nx = (bus.opdata2_i == '0) ? BYZERO : ON;
      BYZERO: state_nx = quit ? IDLE : END;
      ON: state_nx = quit ? IDLE : (cnt == LAST) ? END : ON;
      END: state_nx = quit ? IDLE : END;
    endcase
  end
  // datapath: operand conditioning, iteration and registered result/ready
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      w <= '0;
      dvs <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      bus.ready_o <= 1'b0;
      bus.result_o <= '0;
    end else begin
      bus.ready_o <= state_nx == END;
      case (state)
        IDLE: if (state_nx == ON) begin
          w <= {32'b0, mag_a};
          dvs <= mag_b;
          qneg <= bus.signed_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
          rneg <= bus.signed_i & bus.opdata1_i[31];
          cnt <= '0;
        end
        ON: begin
          w <= w_nx;
          cnt <= cnt + 5'd1;
          if (state_nx == END) bus.result_o <= {rem, quo};
        end
        BYZERO: if (state_nx == END) bus.result_o <= '0;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_divider.sv
// tb_divider: table-driven, scoreboarded check of the divider
module tb_divider;
`ifdef DIVIDER_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif
  typedef struct {
    logic s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int hold;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [63:0] last = '0;
  vec_t v[12];
  divider_if bus();
  divider dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 0) return '0;
    x = s ? longint'(signed'(a)) : longint'(a);
    y = s ? longint'(signed'(b)) : longint'(b);
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp, input int hold);
    int lat;
    int n;
    logic [63:0] e;
    lat = (b == 0) ? 2 : LAT;
    n = 0;
    sb.push_back(exp);
    bus.signed_i = s;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i = 1'b1;
    do begin
      cyc();
      n++;
    end while (!bus.ready_o && n < 100);
    check("latency", 64'(n), 64'(lat));
    e = sb.pop_front();
    check("result", bus.result_o, e);
    repeat (hold) begin
      cyc();
      check("hold_ready", 64'(bus.ready_o), 64'd1);
      check("hold_result", bus.result_o, e);
    end
    bus.start_i = 1'b0;
    cyc();
    check("ready_drop", 64'(bus.ready_o), 64'd0);
    check("result_keep", bus.result_o, e);
    last = e;
  endtask
  initial begin
    v[0] = '{1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 5};
    v[1] = '{1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 1};
    v[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1};
    v[3] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 1};
    v[4] = '{1'b1, 32'h0000007B, 32'h0, 64'h0, 2};
    v[5] = '{1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0};
    v[6] = '{1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0};
    v[7] = '{1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 0};
    v[8] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 0};
    v[9] = '{1'b0, 32'd5, 32'd10, 64'h00000005_00000000, 0};
    v[10] = '{1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 0};
    v[11] = '{1'b0, 32'hFFFFFFFF, 32'h0, 64'h0, 0};
    bus.start_i = 1'b0;
    bus.signed_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    cyc();
    cyc();
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'h0);
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 12; i++) run(v[i].s, v[i].a, v[i].b, v[i].exp, v[i].hold);
    for (int i = 0; i < 8; i++) begin
      logic s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      run(s, a, b, model(s, a, b), 0);
    end
    bus.signed_i = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    repeat (10) cyc();
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    cyc();
    bus.annul_i = 1'b0;
    begin
      int seen = 0;
      repeat (40) begin
        cyc();
        seen += int'(bus.ready_o);
      end
      check("abort_no_ready", 64'(seen), 64'd0);
    end
    check("abort_result", bus.result_o, last);
    run(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0);
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    begin
      int seen = 0;
      repeat (40) begin
        cyc();
        seen += int'(bus.ready_o);
      end
      check("start_annul_ignored", 64'(seen), 64'd0);
    end
    check("start_annul_result", bus.result_o, last);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    cyc();
    run(1'b0, 32'd1000, 32'd9, 64'h00000001_0000006F, 0);
    bus.opdata1_i = 32'd77;
    bus.opdata2_i = 32'd4;
    bus.start_i = 1'b1;
    repeat (6) cyc();
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst_result", bus.result_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    cyc();
    check("post_rst_ready", 64'(bus.ready_o), 64'd0);
    run(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
